spmmio_cmd_initiator: RTL and testbench

- Bus initiator for the spmmio register bus. Converts a byte-wide command stream (from the debug UART / host link) into single-cycle spmmio read and write cycles.
- Returns read data and write acknowledgements as a byte-wide response stream.
- Sits between the host byte link and the spmmio address decoder; it is the only master on its bus segment.

---
 rtl/spmmio_cmd_initiator.sv | 166 ++++++++++++++++
 tb/tb_spmmio_cmd_initiator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spmmio_cmd_initiator.sv
// Byte-stream to spmmio bus initiator: collects a command, runs one cs cycle,
// returns read data (4 bytes) or a write ack (1 byte). Big-endian bit numbering throughout.
module spmmio_cmd_initiator #(
  parameter logic [0:7] ACK_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:7]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [0:7]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:3]  adr,
  output logic        cs,
  output logic [0:3]  sel,
  output logic        we,
  output logic [0:31] d,
  input  logic [0:31] q,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_SEL,
    S_GET_D,
    S_BUS,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [0:31] r_q;
  logic [0:7]  r_out_data;
  logic        r_out_valid;
  logic        r_in_ready;
  logic        r_busy;
  logic        r_cs;
  logic        r_we;
  logic [0:3]  r_adr;
  logic [0:3]  r_sel;
  logic [0:31] r_d;

  logic w_in_acc;
  logic w_out_acc;
  logic w_unused;

  assign w_in_acc  = in_valid && r_in_ready;
  assign w_out_acc = r_out_valid && out_ready;
  // Reserved command bits and the upper nibble of the sel byte carry no meaning.
  assign w_unused  = ^in_data[1:3];

  function automatic logic [0:7] pick_byte(input logic [0:31] w, input logic [1:0] i);
    case (i)
      2'd0:    pick_byte = w[0:7];
      2'd1:    pick_byte = w[8:15];
      2'd2:    pick_byte = w[16:23];
      default: pick_byte = w[24:31];
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_q         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_d         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_acc) begin
            r_adr  <= in_data[4:7];
            r_we   <= in_data[0];
            r_busy <= 1'b1;
            if (in_data[0]) begin
              r_state <= S_GET_SEL;
            end else begin
              r_sel      <= 4'b1111;
              r_cs       <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= S_BUS;
            end
          end
        end
        S_GET_SEL: begin
          if (w_in_acc) begin
            r_sel   <= in_data[4:7];
            r_cnt   <= 2'd0;
            r_state <= S_GET_D;
          end
        end
        S_GET_D: begin
          if (w_in_acc) begin
            case (r_cnt)
              2'd0:    r_d[0:7]   <= in_data;
              2'd1:    r_d[8:15]  <= in_data;
              2'd2:    r_d[16:23] <= in_data;
              default: r_d[24:31] <= in_data;
            endcase
            if (r_cnt == 2'd3) begin
              r_cnt      <= 2'd0;
              r_cs       <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= S_BUS;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        S_BUS: begin
          // q is only trusted while cs is high, so capture it on this closing edge.
          r_cs        <= 1'b0;
          r_cnt       <= 2'd0;
          r_out_valid <= 1'b1;
          if (r_we) begin
            r_out_data <= ACK_BYTE;
          end else begin
            r_q        <= q;
            r_out_data <= q[0:7];
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_out_acc) begin
            if (r_we || r_cnt == 2'd3) begin
              r_cnt       <= 2'd0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_cnt      <= r_cnt + 2'd1;
              r_out_data <= pick_byte(r_q, r_cnt + 2'd1);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cs        <= 1'b0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign adr       = r_adr;
  assign cs        = r_cs;
  assign sel       = r_sel;
  assign we        = r_we;
  assign d         = r_d;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spmmio_cmd_initiator.sv
// Bench for spmmio_cmd_initiator: directed vector table, reset/backpressure corners,
// then a random command stream checked against a word-level register model.
module tb_spmmio_cmd_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:7]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [0:7]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [0:3]  adr;
  logic        cs;
  logic [0:3]  sel;
  logic        we;
  logic [0:31] d;
  logic [0:31] q;
  logic        busy;

  spmmio_cmd_initiator #(.ACK_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .adr(adr), .cs(cs), .sel(sel), .we(we), .d(d), .q(q), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder: plain register file, byte-lane masked writes, combinational read.
  logic [31:0] init_val [16];
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        preloaded = 1'b0;
  logic        prev_cs = 1'b0;
  int          cs_cnt = 0;
  int          cs_double = 0;
  logic [3:0]  cap_adr;
  logic        cap_we;
  logic [3:0]  cap_sel;
  logic [31:0] cap_d;

  assign q = mem[adr];

  always @(posedge clk) begin
    prev_cs <= cs;
    if (!preloaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
      preloaded <= 1'b1;
    end else if (!reset && cs) begin
      cs_cnt  <= cs_cnt + 1;
      if (prev_cs) cs_double <= cs_double + 1;
      cap_adr <= adr;
      cap_we  <= we;
      cap_sel <= sel;
      cap_d   <= d;
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (sel[i]) mem[adr][31-8*i -: 8] <= d[8*i +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Current command and its expectations.
  logic [7:0]  cb [6];
  int          cn;
  logic [3:0]  e_adr;
  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_d;
  logic [31:0] e_rsp;

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", (t >= 200) ? 32'd1 : 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic recv_byte(input int stall, output logic [7:0] b);
    int   t = 0;
    logic ok = 1'b1;
    logic [7:0] held;
    out_ready = 1'b0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("recv_timeout", (t >= 200) ? 32'd1 : 32'd0, 32'd0);
    held = out_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        ok = 1'b0;
    end
    chk("stall_hold", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    b = out_data;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input int gapmax, input int st_lo, input int st_hi);
    int c0;
    logic [7:0] b;
    c0 = cs_cnt;
    for (int k = 0; k < cn; k++) send_byte(cb[k], $urandom_range(gapmax, 0));
    chk({tag, "_lat_cs"}, {30'd0, cs, out_valid}, 32'd2);
    @(negedge clk);
    chk({tag, "_lat_ov"}, {30'd0, cs, out_valid}, 32'd1);
    chk({tag, "_cs_count"}, cs_cnt - c0, 32'd1);
    chk({tag, "_adr"}, {28'd0, cap_adr}, {28'd0, e_adr});
    chk({tag, "_we"}, {31'd0, cap_we}, {31'd0, e_we});
    chk({tag, "_sel"}, {28'd0, cap_sel}, {28'd0, e_sel});
    if (e_we) chk({tag, "_d"}, cap_d, e_d);
    for (int k = 0; k < (e_we ? 1 : 4); k++) begin
      recv_byte($urandom_range(st_hi, st_lo), b);
      chk({tag, "_rsp"}, {24'd0, b}, e_we ? 32'd0 : {24'd0, e_rsp[31-8*k -: 8]});
    end
    chk({tag, "_done"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
  endtask

  typedef struct {
    logic [47:0] bytes;
    int          n;
    logic [3:0]  adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] d;
    logic [31:0] rsp;
  } vec_t;

  vec_t vecs [7];

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < 6; k++) cb[k] = v.bytes[47-8*k -: 8];
    cn = v.n; e_adr = v.adr; e_we = v.we; e_sel = v.sel; e_d = v.d; e_rsp = v.rsp;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [3:0] s, input logic [31:0] w);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ref_mem[a] = (ref_mem[a] & ~m) | (w & m);
  endtask

  initial begin
    logic        rw;
    logic [3:0]  ra, rs;
    logic [31:0] rd;
    for (int i = 0; i < 16; i++) init_val[i] = $urandom;
    init_val[2] = 32'h00AB_CDEF;
    init_val[3] = 32'h1122_3344;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val[i];

    vecs[0] = '{48'h02_0000000000, 1, 4'h2, 1'b0, 4'hF, 32'h0, 32'h00AB_CDEF};
    vecs[1] = '{48'h82_0F_00123456, 6, 4'h2, 1'b1, 4'hF, 32'h0012_3456, 32'h0};
    vecs[2] = '{48'h02_0000000000, 1, 4'h2, 1'b0, 4'hF, 32'h0, 32'h0012_3456};
    vecs[3] = '{48'h83_01_DEADBEEF, 6, 4'h3, 1'b1, 4'h1, 32'hDEAD_BEEF, 32'h0};
    vecs[4] = '{48'h03_0000000000, 1, 4'h3, 1'b0, 4'hF, 32'h0, 32'h1122_33EF};
    vecs[5] = '{48'h83_F0_01020304, 6, 4'h3, 1'b1, 4'h0, 32'h0102_0304, 32'h0};
    vecs[6] = '{48'h73_0000000000, 1, 4'h3, 1'b0, 4'hF, 32'h0, 32'h1122_33EF};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {30'd0, cs, we, out_valid, busy} , 32'd0);
    chk("rst_bus", {adr, sel, 24'd0}, 32'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int v = 0; v < 7; v++) begin
      load_vec(vecs[v]);
      do_cmd($sformatf("vec%0d", v), (v % 2) * 2, 0, v % 3);
      if (vecs[v].we) model_write(vecs[v].adr, vecs[v].sel, vecs[v].d);
    end

    // Backpressure: 5 stalled cycles on every read response byte.
    cb[0] = 8'h02; cn = 1; e_adr = 4'h2; e_we = 1'b0; e_sel = 4'hF; e_rsp = ref_mem[2];
    do_cmd("bp", 0, 5, 5);

    // Reset in the middle of a write: nothing reaches the bus.
    begin
      int c0;
      c0 = cs_cnt;
      send_byte(8'h85, 0);
      send_byte(8'h0F, 1);
      send_byte(8'hAA, 0);
      reset = 1'b1;
      #1;
      chk("midrst_outs", {29'd0, cs, out_valid, busy}, 32'd0);
      chk("midrst_bus", {adr, sel, 24'd0}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_no_cs", cs_cnt - c0, 32'd0);
    end
    cb[0] = 8'h07; cn = 1; e_adr = 4'h7; e_we = 1'b0; e_sel = 4'hF; e_rsp = ref_mem[7];
    do_cmd("after_rst", 0, 0, 0);

    // Random stream against the word-level model.
    for (int n = 0; n < 200; n++) begin
      rw = 1'($urandom);
      ra = 4'($urandom);
      cb[0] = {rw, 3'($urandom), ra};
      e_adr = ra; e_we = rw;
      if (rw) begin
        rs = 4'($urandom);
        rd = $urandom;
        cb[1] = {4'($urandom), rs};
        for (int k = 0; k < 4; k++) cb[2+k] = rd[31-8*k -: 8];
        cn = 6; e_sel = rs; e_d = rd;
      end else begin
        cn = 1; e_sel = 4'hF; e_rsp = ref_mem[ra];
      end
      do_cmd("rand", 3, 0, 3);
      if (rw) model_write(ra, rs, rd);
    end

    chk("cs_single_cycle", cs_double, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
